// File: rtl/execute_stage.sv
// Y86-64 SEQ execute stage: ALU operand select, add/sub/and/xor, ZF/SF/OF register, cond eval.
// Latency: 1 cycle from input transfer to registered valE/cnd; cc updates on the same edge.
// Backpressure: one-entry output register; in_ready = !out_valid || out_ready (no bubble on reload).
module execute_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] valE,
    output logic             cnd,
    output logic [2:0]       cc
);

    // Instruction codes that the execute stage cares about.
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    // ALU function encoding matches the low two bits of the OPq ifun.
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    // Stack pointer adjustment constants.
    localparam logic [WIDTH-1:0] PLUS_EIGHT  = WIDTH'(8);
    localparam logic [WIDTH-1:0] MINUS_EIGHT = ~PLUS_EIGHT + WIDTH'(1);

    // Reset value of the condition codes: {ZF,SF,OF} = {1,0,0}.
    localparam logic [2:0] CC_RESET = 3'b100;

    // Operand / function selection.
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_fn;
    logic             alu_zero;   // force result (and flags) to zero

    // ALU datapath.
    logic [WIDTH-1:0] alu_sum;
    logic [WIDTH-1:0] alu_diff;
    logic [WIDTH-1:0] alu_res;

    // Flags derived from this cycle's ALU result.
    logic flag_z;
    logic flag_s;
    logic flag_o;

    // Condition evaluation on the pre-update cc.
    logic cc_z;
    logic cc_s;
    logic cc_o;
    logic cc_lt;

    // Handshake.
    logic xfer_in;
    logic xfer_out;

    // State and next-state.
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] valE_q, valE_d;
    logic             cnd_q, cnd_d;
    logic [2:0]       cc_q, cc_d;

    // Pick ALU operands and function from the instruction code.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_fn   = ALU_ADD;
        alu_zero = 1'b1;
        case (icode)
            I_RRMOV: begin
                alu_a    = valA;
                alu_zero = 1'b0;
            end
            I_IRMOV: begin
                alu_a    = valC;
                alu_zero = 1'b0;
            end
            I_RMMOV, I_MRMOV: begin
                alu_a    = valC;
                alu_b    = valB;
                alu_zero = 1'b0;
            end
            I_OPQ: begin
                alu_a    = valA;
                alu_b    = valB;
                alu_fn   = ifun[1:0];
                // Undefined OPq functions produce zero rather than aliasing.
                alu_zero = (ifun > 4'd3);
            end
            I_CALL, I_PUSH: begin
                alu_a    = MINUS_EIGHT;
                alu_b    = valB;
                alu_zero = 1'b0;
            end
            I_RET, I_POP: begin
                alu_a    = PLUS_EIGHT;
                alu_b    = valB;
                alu_zero = 1'b0;
            end
            default: begin
                alu_zero = 1'b1;
            end
        endcase
    end

    // 64-bit ALU; carry out is dropped, arithmetic wraps.
    always_comb begin
        alu_sum  = alu_b + alu_a;
        alu_diff = alu_b - alu_a;
        alu_res  = '0;
        case (alu_fn)
            ALU_ADD: alu_res = alu_sum;
            ALU_SUB: alu_res = alu_diff;
            ALU_AND: alu_res = alu_b & alu_a;
            ALU_XOR: alu_res = alu_b ^ alu_a;
            default: alu_res = '0;
        endcase
        if (alu_zero) begin
            alu_res = '0;
        end
    end

    // Condition flags for the current result; overflow only meaningful for add/sub.
    always_comb begin
        flag_z = (alu_res == '0);
        flag_s = alu_res[WIDTH-1];
        flag_o = 1'b0;
        case (alu_fn)
            ALU_ADD: flag_o = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                              (alu_res[WIDTH-1] != alu_b[WIDTH-1]);
            ALU_SUB: flag_o = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                              (alu_res[WIDTH-1] != alu_b[WIDTH-1]);
            default: flag_o = 1'b0;
        endcase
        if (alu_zero) begin
            flag_o = 1'b0;
        end
    end

    // Branch / cmov condition, evaluated against cc before this instruction's update.
    always_comb begin
        cc_z  = cc_q[2];
        cc_s  = cc_q[1];
        cc_o  = cc_q[0];
        cc_lt = cc_s ^ cc_o;
        cnd_d = 1'b0;
        if ((icode == I_RRMOV) || (icode == I_JXX)) begin
            case (ifun)
                4'd0:    cnd_d = 1'b1;
                4'd1:    cnd_d = cc_lt | cc_z;
                4'd2:    cnd_d = cc_lt;
                4'd3:    cnd_d = cc_z;
                4'd4:    cnd_d = ~cc_z;
                4'd5:    cnd_d = ~cc_lt;
                4'd6:    cnd_d = ~cc_lt & ~cc_z;
                default: cnd_d = 1'b0;
            endcase
        end
    end

    // Handshake: accept whenever the output slot is empty or draining this cycle.
    always_comb begin
        in_ready = ~out_valid_q | out_ready;
        xfer_in  = in_valid & in_ready;
        xfer_out = out_valid_q & out_ready;
    end

    // Next-state for the output register and condition codes.
    always_comb begin
        out_valid_d = out_valid_q;
        valE_d      = valE_q;
        cc_d        = cc_q;
        if (xfer_in) begin
            out_valid_d = 1'b1;
            valE_d      = alu_res;
        end else if (xfer_out) begin
            out_valid_d = 1'b0;
        end
        if (xfer_in && (icode == I_OPQ)) begin
            cc_d = {flag_z, flag_s, flag_o};
        end
    end

    // Output register: loads on input transfer, holds data when draining or stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            valE_q      <= '0;
            cnd_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            valE_q      <= valE_d;
            if (xfer_in) begin
                cnd_q <= cnd_d;
            end
        end
    end

    // Condition-code register: written only by accepted OPq instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= CC_RESET;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign valE      = valE_q;
    assign cnd       = cnd_q;
    assign cc        = cc_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized traffic.
// A behavioural model tracks the expected output register and cc every cycle.
// Random in_valid/out_ready exercise stalls, simultaneous transfers and drains.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valE;
    logic        cnd;
    logic [2:0]  cc;

    int checks;
    int failures;
    bit checking;

    // Model state.
    bit          m_ov;
    logic [63:0] m_vale;
    bit          m_cnd;
    logic [2:0]  m_cc;
    bit          m_acc;
    logic [63:0] m_r;

    execute_stage #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .ifun      (ifun),
        .valA      (valA),
        .valB      (valB),
        .valC      (valC),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .valE      (valE),
        .cnd       (cnd),
        .cc        (cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // OPq result as plain arithmetic on (valB op valA).
    function automatic logic [63:0] ref_opq(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
        case (f)
            4'd0:    return b + a;
            4'd1:    return b - a;
            4'd2:    return b & a;
            4'd3:    return b ^ a;
            default: return 64'd0;
        endcase
    endfunction

    // Signed overflow: the 65-bit exact result does not fit in 64 signed bits.
    function automatic logic ref_of(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [64:0] w;
        if (f == 4'd0) w = {b[63], b} + {a[63], a};
        else if (f == 4'd1) w = {b[63], b} - {a[63], a};
        else return 1'b0;
        return w[64] != w[63];
    endfunction

    function automatic logic [63:0] ref_vale(input logic [3:0] ic, input logic [3:0] f,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
        case (ic)
            4'h2:        return a;
            4'h3:        return c;
            4'h4, 4'h5:  return b + c;
            4'h6:        return ref_opq(f, a, b);
            4'h8, 4'hA:  return b - 64'd8;
            4'h9, 4'hB:  return b + 64'd8;
            default:     return 64'd0;
        endcase
    endfunction

    function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] f, input logic [2:0] c);
        logic z, lt;
        if (ic != 4'h2 && ic != 4'h7) return 1'b0;
        z  = c[2];
        lt = (c[1] != c[0]);
        case (f)
            4'd0:    return 1'b1;
            4'd1:    return lt || z;
            4'd2:    return lt;
            4'd3:    return z;
            4'd4:    return !z;
            4'd5:    return !lt;
            4'd6:    return !lt && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural model of the stage, advanced on every rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ov   = 1'b0;
            m_vale = 64'd0;
            m_cnd  = 1'b0;
            m_cc   = 3'b100;
        end else begin
            m_acc = in_valid && (!m_ov || out_ready);
            if (m_acc) begin
                m_vale = ref_vale(icode, ifun, valA, valB, valC);
                m_cnd  = ref_cnd(icode, ifun, m_cc);
                m_ov   = 1'b1;
                if (icode == 4'h6) begin
                    m_r  = ref_opq(ifun, valA, valB);
                    m_cc = {m_r == 64'd0, m_r[63], ref_of(ifun, valA, valB)};
                end
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking && !rst) begin
            chk("m_in_ready", 64'(in_ready), 64'(!m_ov || out_ready));
            chk("m_out_valid", 64'(out_valid), 64'(m_ov));
            chk("m_valE", valE, m_vale);
            chk("m_cnd", 64'(cnd), 64'(m_cnd));
            chk("m_cc", 64'(cc), 64'(m_cc));
        end
    end

    task automatic drive(input logic [3:0] ic, input logic [3:0] f,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        icode    = ic;
        ifun     = f;
        valA     = a;
        valB     = b;
        valC     = c;
        in_valid = 1'b1;
    endtask

    // Wait until the presented instruction is accepted; returns #1 after that edge.
    task automatic wait_accept(input string nm);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s: not accepted within 20 cycles", nm);
        end
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        checks    = 0;
        failures  = 0;
        checking  = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        icode     = 4'h0;
        ifun      = 4'h0;
        valA      = 64'd0;
        valB      = 64'd0;
        valC      = 64'd0;

        // Reset values, before any clock edge.
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_valE", valE, 64'd0);
        chk("rst_cnd", 64'(cnd), 64'd0);
        chk("rst_cc", 64'(cc), 64'(3'b100));
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        checking = 1'b1;

        // Signed overflow on add.
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        wait_accept("add_ovf");
        chk("add_ovf_valE", valE, 64'h8000_0000_0000_0000);
        chk("add_ovf_cc", 64'(cc), 64'(3'b011));
        chk("add_ovf_valid", 64'(out_valid), 64'd1);

        // sub 5-5 then je back-to-back.
        drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
        wait_accept("sub_eq");
        chk("sub_eq_valE", valE, 64'd0);
        chk("sub_eq_cc", 64'(cc), 64'(3'b100));
        drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
        wait_accept("je");
        chk("je_cnd", 64'(cnd), 64'd1);
        chk("je_valE", valE, 64'd0);

        // push / pop stack arithmetic.
        drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
        wait_accept("push");
        chk("push_valE", valE, 64'hF8);
        drive(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0);
        wait_accept("pop");
        chk("pop_valE", valE, 64'h100);
        chk("pop_cc", 64'(cc), 64'(3'b100));
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Backpressure with an irmov pending and an OPq held at the input.
        out_ready = 1'b0;
        drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234);
        wait_accept("irmov");
        drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valE", valE, 64'h1234);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_cc", 64'(cc), 64'(3'b100));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept("held_add");
        chk("held_add_valE", valE, 64'd2);
        chk("held_add_cc", 64'(cc), 64'(3'b000));

        // Eight back-to-back and/xor at full throughput.
        for (int i = 0; i < 8; i++) begin
            drive(4'h6, 4'(2 + (i % 2)), 64'h8000_0000_0000_0000 | 64'(i * 37),
                  64'hF0F0_F0F0_F0F0_F0F0, 64'd0);
            wait_accept("logic_op");
            chk("tp_out_valid", 64'(out_valid), 64'd1);
            chk("tp_of", 64'(cc[0]), 64'd0);
        end
        in_valid = 1'b0;
        // Last one was xor of 0x8000..0103 with 0xF0F0..F0F0.
        chk("tp_last_valE", valE, 64'h70F0_F0F0_F0F0_F1F3);
        @(posedge clk);
        #1;

        // Reset while a result is pending and cc={0,1,0}.
        drive(4'h6, 4'h1, 64'd1, 64'd0, 64'd0);
        wait_accept("sub_neg");
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("sub_neg_cc", 64'(cc), 64'(3'b010));
        chk("sub_neg_valE", valE, 64'hFFFF_FFFF_FFFF_FFFF);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_valE", valE, 64'd0);
        chk("mid_rst_cc", 64'(cc), 64'(3'b100));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(4'h3, 4'h0, 64'd0, 64'd0, 64'h55);
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_valE", valE, 64'h55);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            icode     = 4'($urandom_range(0, 15));
            ifun      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 6));
            valA      = pick();
            valB      = pick();
            valC      = pick();
            @(posedge clk);
            #1;
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
